// File: rtl/bp_cfg_tile_sequencer.sv
// Boot sequencer: maps a configuration select to a core count, then programs each
// tile's core/CCE IDs over a valid/ready stream and finally unfreezes every tile.
module bp_cfg_tile_sequencer #(
    parameter int lg_max_cfgs_p    = 7,
    parameter int tile_id_width_p  = 5,
    parameter int cfg_addr_width_p = 4,
    parameter int cfg_data_width_p = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [lg_max_cfgs_p-1:0]      cfg_sel_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [tile_id_width_p:0]      num_cores_o,
    output logic                          cfg_v_o,
    input  logic                          cfg_ready_i,
    output logic [tile_id_width_p-1:0]    cfg_tile_o,
    output logic [cfg_addr_width_p-1:0]   cfg_addr_o,
    output logic [cfg_data_width_p-1:0]   cfg_data_o
);

    typedef logic [tile_id_width_p:0]    count_t;
    typedef logic [tile_id_width_p-1:0]  tile_t;
    typedef logic [cfg_addr_width_p-1:0] addr_t;
    typedef logic [cfg_data_width_p-1:0] data_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WR_ID,
        S_WR_CCE,
        S_UNFREEZE,
        S_DONE
    } state_e;

    // A count of zero marks an unsupported configuration.
    function automatic count_t cores_for(input logic [lg_max_cfgs_p-1:0] sel);
        count_t n;
        case (int'(sel))
            1, 2, 3: n = count_t'(1);
            4:       n = count_t'(2);
            5:       n = count_t'(3);
            6:       n = count_t'(4);
            7:       n = count_t'(6);
            8:       n = count_t'(8);
            9:       n = count_t'(12);
            10:      n = count_t'(16);
            default: n = '0;
        endcase
        return n;
    endfunction

    state_e                   state_q, state_d;
    logic [lg_max_cfgs_p-1:0] sel_q, sel_d;
    count_t                   cores_q, cores_d;
    count_t                   lookup_cores;
    tile_t                    tile_q, tile_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     v_q, v_d;
    tile_t                    out_tile_q, out_tile_d;
    addr_t                    addr_q, addr_d;
    data_t                    data_q, data_d;
    logic                     xfer;
    logic                     last_tile;

    assign xfer         = v_q & cfg_ready_i;
    assign last_tile    = (count_t'(tile_q) == (cores_q - count_t'(1)));
    assign lookup_cores = cores_for(sel_q);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            cores_q    <= '0;
            tile_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            v_q        <= 1'b0;
            out_tile_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cores_q    <= cores_d;
            tile_q     <= tile_d;
            done_q     <= done_d;
            error_q    <= error_d;
            v_q        <= v_d;
            out_tile_q <= out_tile_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cores_d = cores_q;
        tile_d  = tile_q;
        done_d  = done_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sel_d   = cfg_sel_i;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                tile_d = '0;
                if (lookup_cores == '0) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cores_d = lookup_cores;
                    state_d = S_WR_ID;
                end
            end
            S_WR_ID: begin
                if (xfer) begin
                    state_d = S_WR_CCE;
                end
            end
            S_WR_CCE: begin
                if (xfer) begin
                    if (last_tile) begin
                        tile_d  = '0;
                        state_d = S_UNFREEZE;
                    end else begin
                        tile_d  = tile_q + 1'b1;
                        state_d = S_WR_ID;
                    end
                end
            end
            S_UNFREEZE: begin
                if (xfer) begin
                    if (last_tile) begin
                        state_d = S_DONE;
                    end else begin
                        tile_d = tile_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stream outputs are registered from the next state so they hold during stalls.
        v_d        = (state_d == S_WR_ID) || (state_d == S_WR_CCE) || (state_d == S_UNFREEZE);
        out_tile_d = v_d ? tile_d : '0;
        case (state_d)
            S_WR_ID:    addr_d = addr_t'(0);
            S_WR_CCE:   addr_d = addr_t'(1);
            S_UNFREEZE: addr_d = addr_t'(2);
            default:    addr_d = '0;
        endcase
        data_d = ((state_d == S_WR_ID) || (state_d == S_WR_CCE)) ? data_t'(tile_d) : '0;
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign num_cores_o = cores_q;
    assign cfg_v_o     = v_q;
    assign cfg_tile_o  = out_tile_q;
    assign cfg_addr_o  = addr_q;
    assign cfg_data_o  = data_q;

endmodule

// File: tb/tb_bp_cfg_tile_sequencer.sv
// Self-checking bench for bp_cfg_tile_sequencer: table-driven runs, directed corner
// sequences and randomized runs checked against a write-list reference model.
module tb_bp_cfg_tile_sequencer;

    localparam int LG = 7;
    localparam int TW = 5;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [LG-1:0] cfg_sel_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [TW:0]   num_cores_o;
    logic          cfg_v_o;
    logic          cfg_ready_i;
    logic [TW-1:0] cfg_tile_o;
    logic [AW-1:0] cfg_addr_o;
    logic [DW-1:0] cfg_data_o;

    bp_cfg_tile_sequencer #(
        .lg_max_cfgs_p    (LG),
        .tile_id_width_p  (TW),
        .cfg_addr_width_p (AW),
        .cfg_data_width_p (DW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .cfg_sel_i   (cfg_sel_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .num_cores_o (num_cores_o),
        .cfg_v_o     (cfg_v_o),
        .cfg_ready_i (cfg_ready_i),
        .cfg_tile_o  (cfg_tile_o),
        .cfg_addr_o  (cfg_addr_o),
        .cfg_data_o  (cfg_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int tile;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int sel;
        int expN;
        int expDone;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   refCores[11] = '{0, 1, 1, 1, 2, 3, 4, 6, 8, 12, 16};
    vec_t vecs[13];
    int   nWrites;
    int   rSel;
    int   rN;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_done"}, done_o, 0);
        checkOutput({tag, "_error"}, error_o, 0);
        checkOutput({tag, "_num_cores"}, num_cores_o, 0);
        checkOutput({tag, "_cfg_v"}, cfg_v_o, 0);
        checkOutput({tag, "_cfg_tile"}, cfg_tile_o, 0);
        checkOutput({tag, "_cfg_addr"}, cfg_addr_o, 0);
        checkOutput({tag, "_cfg_data"}, cfg_data_o, 0);
    endtask

    // One complete run from start acceptance to done/error. mode: 0 ready high,
    // 1 ready toggling, 2 random ready. expDone > 0 fixes the finishing cycle.
    task automatic applyStimulus(input int sel, input int expN, input int mode,
                                 input int pulseAt, input int expDone);
        wr_t q[$];
        wr_t w;
        int  c;
        int  writes;
        int  lastXfer;
        bit  finished;
        bit  prevStall;
        for (int t = 0; t < expN; t++) begin
            w.tile = t; w.addr = 0; w.data = t;
            q.push_back(w);
            w.addr = 1;
            q.push_back(w);
        end
        for (int t = 0; t < expN; t++) begin
            w.tile = t; w.addr = 2; w.data = 0;
            q.push_back(w);
        end
        start_i     = 1'b1;
        cfg_sel_i   = LG'(sel);
        cfg_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        c = 1; writes = 0; lastXfer = 0; finished = 1'b0; prevStall = 1'b0;
        while (!finished && c < 4000) begin
            if (c == pulseAt) begin
                start_i   = 1'b1;
                cfg_sel_i = LG'(1);
            end else begin
                start_i   = 1'b0;
                cfg_sel_i = LG'($urandom_range(0, 127));
            end
            case (mode)
                0:       cfg_ready_i = 1'b1;
                1:       cfg_ready_i = (c % 2 == 0);
                default: cfg_ready_i = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk_i);
            if (c == 1) begin
                checkOutput("lookup_busy", busy_o, 1);
                checkOutput("lookup_cfg_v", cfg_v_o, 0);
                checkOutput("lookup_done_cleared", done_o, 0);
                checkOutput("lookup_error_cleared", error_o, 0);
            end
            if (expN > 0 && c == 2) checkOutput("first_write_latency", cfg_v_o, 1);
            if (expN > 0 && c >= 2) checkOutput("num_cores", num_cores_o, expN);
            if (prevStall) checkOutput("valid_held_in_stall", cfg_v_o, 1);
            if (cfg_v_o) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    checkOutput("wr_tile", cfg_tile_o, q[0].tile);
                    checkOutput("wr_addr", cfg_addr_o, q[0].addr);
                    checkOutput("wr_data", cfg_data_o, q[0].data);
                    if (cfg_ready_i) begin
                        void'(q.pop_front());
                        writes++;
                        lastXfer = c;
                    end
                end
            end
            prevStall = cfg_v_o && !cfg_ready_i;
            if (done_o || error_o) begin
                finished = 1'b1;
            end else begin
                @(posedge clk_i);
                #1;
                c++;
            end
        end
        if (!finished) begin
            checkOutput("run_timeout", 0, 1);
        end else begin
            checkOutput("end_done", done_o, (expN > 0) ? 1 : 0);
            checkOutput("end_error", error_o, (expN == 0) ? 1 : 0);
            checkOutput("end_busy", busy_o, 0);
            checkOutput("write_count", writes, 3 * expN);
            if (expN > 0) checkOutput("done_after_last_write", c, lastXfer + 2);
            if (expDone > 0) checkOutput("end_cycle", c, expDone);
        end
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3, 1, 6};
        vecs[1]  = '{10, 16, 51};
        vecs[2]  = '{1, 1, 6};
        vecs[3]  = '{2, 1, 6};
        vecs[4]  = '{0, 0, 2};
        vecs[5]  = '{11, 0, 2};
        vecs[6]  = '{4, 2, 9};
        vecs[7]  = '{5, 3, 12};
        vecs[8]  = '{6, 4, 15};
        vecs[9]  = '{7, 6, 21};
        vecs[10] = '{8, 8, 27};
        vecs[11] = '{9, 12, 39};
        vecs[12] = '{127, 0, 2};

        reset_i     = 1'b1;
        start_i     = 1'b0;
        cfg_sel_i   = '0;
        cfg_ready_i = 1'b0;
        #22;
        checkAllZero("reset");
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        $display("[TB] table-driven runs, ready held high");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].expN, 0, 0, vecs[i].expDone);
        end

        $display("[TB] sel=6 with ready toggling");
        applyStimulus(6, 4, 1, 0, 0);

        $display("[TB] sel=9 aborted by reset after five writes");
        start_i     = 1'b1;
        cfg_sel_i   = LG'(9);
        cfg_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        nWrites = 0;
        for (int k = 0; k < 40 && nWrites < 5; k++) begin
            @(negedge clk_i);
            if (cfg_v_o && cfg_ready_i) nWrites++;
            @(posedge clk_i);
            #1;
        end
        checkOutput("writes_before_reset", nWrites, 5);
        reset_i = 1'b1;
        #1;
        checkAllZero("mid_run_reset");
        @(negedge clk_i);
        checkOutput("reset_no_write", cfg_v_o, 0);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        applyStimulus(9, 12, 0, 0, 39);

        $display("[TB] start pulse with sel=1 during a sel=5 run");
        applyStimulus(5, 3, 0, 4, 12);

        $display("[TB] start held only in the DONE cycle");
        applyStimulus(2, 1, 0, 5, 6);
        @(negedge clk_i);
        checkOutput("done_cycle_start_ignored", busy_o, 0);
        @(posedge clk_i);
        #1;

        $display("[TB] randomized runs against the reference model");
        for (int i = 0; i < 20; i++) begin
            rSel = (i % 5 == 4) ? $urandom_range(11, 127) : $urandom_range(0, 10);
            rN   = (rSel <= 10) ? refCores[rSel] : 0;
            applyStimulus(rSel, rN, 2, 0, (rN == 0) ? 2 : 0);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
